rgb565_frame_writer: RTL and testbench

//  Sink end of the ISP pixel stream: consumes 16-bit RGB565 pixels qualified by

---
 rtl/rgb565_frame_writer_pkg.sv | 32 +++
 rtl/rgb565_frame_writer_fifo.sv | 53 +++++
 rtl/rgb565_frame_writer.sv | 117 +++++++++++
 tb/tb_rgb565_frame_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb565_frame_writer_pkg.sv
// Shared types and constants for the RGB565 frame writer: FSM encoding,
// pixel field positions and FIFO entry geometry.
package rgb565_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } fw_state_t;

  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

  localparam int PIX_W   = 16;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int ENTRY_W = ADDR_W + WORD_W;

  localparam int DEF_IMG_W     = 640;
  localparam int DEF_IMG_H     = 480;
  localparam int PIX_PER_FRAME = DEF_IMG_W * DEF_IMG_H;

  function automatic logic [31:0] pix_per_frame(input int w, input int h);
    return 32'(w * h);
  endfunction

endpackage

// File: rtl/rgb565_frame_writer_fifo.sv
// Synchronous word FIFO holding {addr, data} entries; the head is read straight
// from the storage registers, and a push into a full FIFO succeeds if it pops too.
module pix_word_fifo
  import rgb565_frame_writer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         one_left_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign one_left_o = (cnt_q == (AW+1)'(1));
  assign head_o     = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rgb565_frame_writer.sv
// Frame sink: packs RGB565 pixel pairs into 32-bit words with byte addresses and
// streams them to frame memory through a small FIFO.
module rgb565_frame_writer
  import rgb565_frame_writer_pkg::*;
#(
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic [15:0] Din,
  input  logic        dataEn,
  output logic [31:0] wrAddr,
  output logic [31:0] wrData,
  output logic        wrValid,
  input  logic        wrReady,
  output logic        frameDone,
  output logic        overflow,
  output logic        busy,
  output fw_state_t   state_o
);
  localparam logic [31:0] LAST_PIX = pix_per_frame(IMG_W, IMG_H) - 32'd1;

  fw_state_t          state_q, state_d;
  logic [31:0]        pix_cnt_q, pix_cnt_d;
  logic [31:0]        word_idx_q, word_idx_d;
  logic [PIX_W-1:0]   pack_q, pack_d;
  logic               overflow_q, overflow_d;

  logic               accept, push, pop;
  logic [31:0]        pix_idx;
  logic [ENTRY_W-1:0] push_entry, head;
  logic               fifo_empty, fifo_full, fifo_one;

  // Write handshake: the head entry transfers on any cycle where wrValid and
  // wrReady are both high; while wrValid is high and wrReady low the head holds.
  assign pop       = wrValid && wrReady;
  assign wrValid   = !fifo_empty;
  assign wrAddr    = head[ENTRY_W-1:WORD_W];
  assign wrData    = head[WORD_W-1:0];
  assign frameDone = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = overflow_q;
  assign state_o   = state_q;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    overflow_d = overflow_q;
    accept     = dataEn && (sof || state_q == ST_ACTIVE);
    pix_idx    = sof ? 32'd0 : pix_cnt_q;
    push       = accept && pix_idx[0];
    push_entry = {BASE_ADDR + {word_idx_q[29:0], 2'b00}, Din, pack_q};

    if (sof) begin
      state_d    = ST_ACTIVE;
      pix_cnt_d  = '0;
      word_idx_d = '0;
      pack_d     = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        // Leave DRAIN on the edge that pops the final entry so frameDone
        // follows the last handshake by one cycle.
        ST_DRAIN: if (fifo_empty || (fifo_one && pop)) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  ;
      endcase
    end

    if (accept) begin
      pix_cnt_d = pix_idx + 32'd1;
      if (pix_idx[0]) word_idx_d = word_idx_q + 32'd1;
      else            pack_d     = Din;
      if (pix_idx == LAST_PIX) state_d = ST_DRAIN;
    end

    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      overflow_q <= overflow_d;
    end
  end

  pix_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .data_i     (push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .one_left_o (fifo_one)
  );

endmodule

// File: tb/tb_rgb565_frame_writer.sv
// Bench for rgb565_frame_writer: a 4x2 instance with a deep FIFO and a 4x3
// instance with a 4-entry FIFO share one stimulus stream.
module tb_rgb565_frame_writer;
  import rgb565_frame_writer_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, sof = 1'b0, dataEn = 1'b0, wrReady = 1'b0;
  logic [15:0] Din = '0;

  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic        a_valid, a_done, a_ovf, a_busy;
  logic        b_valid, b_done, b_ovf, b_busy;
  fw_state_t   a_state, b_state;

  always #5 clk = ~clk;

  rgb565_frame_writer #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(32'h0), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .sof(sof), .Din(Din), .dataEn(dataEn),
    .wrAddr(a_addr), .wrData(a_data), .wrValid(a_valid), .wrReady(wrReady),
    .frameDone(a_done), .overflow(a_ovf), .busy(a_busy), .state_o(a_state));

  rgb565_frame_writer #(.IMG_W(4), .IMG_H(3), .BASE_ADDR(32'h0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .sof(sof), .Din(Din), .dataEn(dataEn),
    .wrAddr(b_addr), .wrData(b_data), .wrValid(b_valid), .wrReady(wrReady),
    .frameDone(b_done), .overflow(b_ovf), .busy(b_busy), .state_o(b_state));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];
  bit mon_a = 1'b0, mon_b = 1'b0;
  int a_done_cnt = 0, b_done_cnt = 0, a_last_hs = 0, b_last_hs = 0;

  typedef struct {
    logic [15:0] px_lo;
    logic [15:0] px_hi;
    logic [31:0] addr;
    logic [31:0] data;
  } pair_vec_t;
  pair_vec_t tab[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitors: compare every handshake and every stalled head against the queue
  always @(negedge clk) begin
    if (mon_a && !rst) begin
      if (a_valid && wrReady) begin
        if (exp_a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_write: got %0h/%0h expected no write", a_addr, a_data);
        end else begin
          chk("a_write", {a_addr, a_data}, exp_a_q.pop_front());
          a_last_hs = cyc;
        end
      end else if (a_valid && exp_a_q.size() != 0) begin
        chk("a_stall_head", {a_addr, a_data}, exp_a_q[0]);
      end
      if (a_done) begin
        a_done_cnt++;
        chk("a_done_timing", 64'(cyc), 64'(a_last_hs + 1));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_b && !rst) begin
      if (b_valid && wrReady) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_write: got %0h/%0h expected no write", b_addr, b_data);
        end else begin
          chk("b_write", {b_addr, b_data}, exp_b_q.pop_front());
          b_last_hs = cyc;
        end
      end else if (b_valid && exp_b_q.size() != 0) begin
        chk("b_stall_head", {b_addr, b_data}, exp_b_q[0]);
      end
      if (b_done) begin
        b_done_cnt++;
        chk("b_done_timing", 64'(cyc), 64'(b_last_hs + 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [15:0] v, input logic s);
    sof = s; dataEn = 1'b1; Din = v;
    tick();
    sof = 1'b0; dataEn = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1; sof = 1'b0; dataEn = 1'b0; wrReady = 1'b0;
    tick();
    @(negedge clk);
    chk({name, "_a_valid"}, a_valid, 0);
    chk({name, "_a_busy"}, a_busy, 0);
    chk({name, "_a_ovf"}, a_ovf, 0);
    chk({name, "_a_done"}, a_done, 0);
    chk({name, "_a_head"}, {a_addr, a_data}, 0);
    chk({name, "_b_valid"}, b_valid, 0);
    chk({name, "_b_busy"}, b_busy, 0);
    chk({name, "_b_ovf"}, b_ovf, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 4; i++) begin
      pix(tab[base+i].px_lo, (i == 0));
      pix(tab[base+i].px_hi, 1'b0);
    end
  endtask

  task automatic expect_frame_a(input int base);
    for (int i = 0; i < 4; i++) exp_a_q.push_back({tab[base+i].addr, tab[base+i].data});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_pending_writes"}, 64'(exp_a_q.size() + exp_b_q.size()), 0);
    repeat (4) tick();
  endtask

  initial begin
    tab[0] = '{16'h0001, 16'h0002, 32'h0, 32'h00020001};
    tab[1] = '{16'h0003, 16'h0004, 32'h4, 32'h00040003};
    tab[2] = '{16'h0005, 16'h0006, 32'h8, 32'h00060005};
    tab[3] = '{16'h0007, 16'h0008, 32'hC, 32'h00080007};
    tab[4] = '{16'h0011, 16'h0012, 32'h0, 32'h00120011};
    tab[5] = '{16'h0013, 16'h0014, 32'h4, 32'h00140013};
    tab[6] = '{16'h0015, 16'h0016, 32'h8, 32'h00160015};
    tab[7] = '{16'h0017, 16'h0018, 32'hC, 32'h00180017};

    do_reset("reset");

    // dataEn without sof is ignored
    mon_a = 1'b1; mon_b = 1'b1; wrReady = 1'b1;
    for (int i = 0; i < 4; i++) pix(16'(i + 16'h20), 1'b0);
    @(negedge clk);
    chk("nosof_a_busy", a_busy, 0);
    chk("nosof_a_valid", a_valid, 0);
    chk("nosof_b_busy", b_busy, 0);
    tick();

    // Contiguous frame, memory always ready; pixel 0 arrives with sof
    mon_b = 1'b0; a_done_cnt = 0;
    expect_frame_a(0);
    send_frame(0);
    wait_drain("t1", 40);
    chk("t1_done_cnt", 64'(a_done_cnt), 1);
    chk("t1_a_state", a_state, ST_IDLE);

    // Same frame stalled until all pixels are in
    wrReady = 1'b0; a_done_cnt = 0;
    expect_frame_a(0);
    send_frame(0);
    repeat (3) tick();
    @(negedge clk);
    chk("t2_a_ovf", a_ovf, 0);
    chk("t2_a_state", a_state, ST_DRAIN);
    chk("t2_a_done_in_drain", a_done, 0);
    tick();
    wrReady = 1'b1;
    wait_drain("t2", 40);
    chk("t2_done_cnt", 64'(a_done_cnt), 1);

    // 4-entry FIFO overflows on words 4 and 5
    do_reset("t3_rst");
    mon_a = 1'b0; mon_b = 1'b1; b_done_cnt = 0;
    for (int i = 0; i < 4; i++) exp_b_q.push_back({tab[i].addr, tab[i].data});
    send_frame(0);
    for (int v = 9; v <= 12; v++) pix(16'(v), 1'b0);
    @(negedge clk);
    chk("t3_b_ovf_set", b_ovf, 1);
    chk("t3_b_state", b_state, ST_DRAIN);
    tick();
    wrReady = 1'b1;
    wait_drain("t3", 40);
    chk("t3_done_cnt", 64'(b_done_cnt), 1);
    chk("t3_b_ovf_sticky", b_ovf, 1);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    @(negedge clk);
    chk("t3_b_ovf_cleared", b_ovf, 0);
    tick();

    // sof after three pixels restarts packing; the early word still goes first
    do_reset("t4_rst");
    mon_a = 1'b1; mon_b = 1'b0; wrReady = 1'b1; a_done_cnt = 0;
    exp_a_q.push_back({32'h0, 32'h00020001});
    expect_frame_a(4);
    pix(16'h0001, 1'b1);
    pix(16'h0002, 1'b0);
    pix(16'h0003, 1'b0);
    send_frame(4);
    wait_drain("t4", 40);
    chk("t4_done_cnt", 64'(a_done_cnt), 1);

    // Reset while a write is pending
    mon_a = 1'b0; wrReady = 1'b0;
    send_frame(0);
    for (int v = 9; v <= 12; v++) pix(16'(v), 1'b0);
    @(negedge clk);
    chk("t5_a_valid_pre", a_valid, 1);
    chk("t5_b_ovf_pre", b_ovf, 1);
    tick();
    do_reset("t5_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
